// File: rtl/led_scan_pkg.sv
// Shared definitions for the 7-segment scan decoder: digit codes, active-low
// segment patterns {g,f,e,d,c,b,a} and the sampling FSM states.
package led_scan_pkg;

    localparam logic [3:0] DIG_BLANK = 4'hF;
    localparam logic [3:0] DIG_BAD   = 4'hE;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0011000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [0:0] {
        SETTLE = 1'b0,
        HOLD   = 1'b1
    } scan_state_e;

    function automatic logic [3:0] low_count(input logic [7:0] en);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, ~en[i]};
        end
        return n;
    endfunction

    // Position of the lowest active (low) enable; only meaningful for one-low inputs.
    function automatic logic [2:0] low_pos(input logic [7:0] en);
        logic [2:0] p;
        p = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (!en[i]) begin
                p = 3'(i);
            end else begin
                p = p;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/led_scan_decoder_seg7_to_bcd.sv
// Combinational decode of an active-low 7-segment pattern into a digit code.
module seg7_to_bcd
    import led_scan_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] code,
    output logic       bad
);

    // Pattern lookup; anything outside the digit set or blank is undecodable.
    always_comb begin
        code = DIG_BAD;
        bad  = 1'b1;
        case (seg)
            SEG_0:     begin code = 4'd0;      bad = 1'b0; end
            SEG_1:     begin code = 4'd1;      bad = 1'b0; end
            SEG_2:     begin code = 4'd2;      bad = 1'b0; end
            SEG_3:     begin code = 4'd3;      bad = 1'b0; end
            SEG_4:     begin code = 4'd4;      bad = 1'b0; end
            SEG_5:     begin code = 4'd5;      bad = 1'b0; end
            SEG_6:     begin code = 4'd6;      bad = 1'b0; end
            SEG_7:     begin code = 4'd7;      bad = 1'b0; end
            SEG_8:     begin code = 4'd8;      bad = 1'b0; end
            SEG_9:     begin code = 4'd9;      bad = 1'b0; end
            SEG_BLANK: begin code = DIG_BLANK; bad = 1'b0; end
            default:   begin code = DIG_BAD;   bad = 1'b1; end
        endcase
    end

endmodule

// File: rtl/led_scan_decoder.sv
// Reconstructs the eight digits shown by a multiplexed 7-segment controller
// and flags malformed scans and stalled scanning.
module led_scan_decoder
    import led_scan_pkg::*;
#(
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 1048576,
    parameter int TO_W        = 21
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  led_en,
    input  logic        led_ca,
    input  logic        led_cb,
    input  logic        led_cc,
    input  logic        led_cd,
    input  logic        led_ce,
    input  logic        led_cf,
    input  logic        led_cg,
    input  logic        led_dp,
    output logic [31:0] digits,
    output logic        frame_valid,
    output logic        en_err,
    output logic        seg_err,
    output logic        dp_err,
    output logic        scan_timeout,
    output logic        err_pulse
);

    localparam logic [3:0]      STAB_LAST = 4'(STABLE_CYC - 1);
    localparam logic [TO_W-1:0] TO_MAX    = TO_W'(TIMEOUT_CYC);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [TO_W-1:0] TO_ONE    = TO_W'(1);

    logic [15:0]     in_q_r, in_prev_r;   // {led_en, g..a, dp}
    logic [3:0]      stab_cnt_r;
    scan_state_e     state_r;
    logic [7:0]      mask_r, cap_mask_s;
    logic [31:0]     shadow_r, cap_shadow_s, digits_r;
    logic [TO_W-1:0] to_cnt_r;
    logic            frame_valid_r, err_pulse_r, en_err_r, seg_err_r, dp_err_r, scan_timeout_r;

    logic            same_s, accept_s, single_s, multi_s, cap_s, frame_done_s;
    logic            en_hit_s, seg_hit_s, dp_hit_s, bad_s;
    logic [3:0]      low_cnt_s, code_s;
    logic [2:0]      pos_s;

    assign same_s    = (in_q_r == in_prev_r);
    assign accept_s  = (state_r == SETTLE) && same_s && (stab_cnt_r == STAB_LAST);
    assign low_cnt_s = low_count(in_q_r[15:8]);
    assign pos_s     = low_pos(in_q_r[15:8]);
    assign single_s  = (low_cnt_s == 4'd1);
    assign multi_s   = (low_cnt_s >= 4'd2);
    assign cap_s     = accept_s && single_s;
    assign en_hit_s  = accept_s && multi_s;
    assign seg_hit_s = cap_s && bad_s;
    assign dp_hit_s  = cap_s && !in_q_r[0];

    seg7_to_bcd u_seg7_to_bcd (
        .seg  (in_q_r[7:1]),
        .code (code_s),
        .bad  (bad_s)
    );

    // Shadow/mask contents after this cycle's capture, before frame hand-off.
    always_comb begin
        cap_mask_s   = mask_r;
        cap_shadow_s = shadow_r;
        if (cap_s) begin
            cap_mask_s[pos_s]                  = 1'b1;
            cap_shadow_s[{pos_s, 2'b00} +: 4] = code_s;
        end else begin
            cap_mask_s   = mask_r;
            cap_shadow_s = shadow_r;
        end
    end

    assign frame_done_s = cap_s && (cap_mask_s == 8'hFF);

    // Input sampling pipeline; idle bus value is all ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_q_r    <= 16'hFFFF;
            in_prev_r <= 16'hFFFF;
        end else begin
            in_q_r    <= {led_en, led_cg, led_cf, led_ce, led_cd, led_cc, led_cb, led_ca, led_dp};
            in_prev_r <= in_q_r;
        end
    end

    // Stability FSM: one acceptance per stable interval, rearmed by any change.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= SETTLE;
            stab_cnt_r <= 4'd0;
        end else if (!same_s) begin
            state_r    <= SETTLE;
            stab_cnt_r <= 4'd0;
        end else if (state_r == SETTLE) begin
            if (stab_cnt_r == STAB_LAST) begin
                state_r <= HOLD;
            end else begin
                stab_cnt_r <= stab_cnt_r + 4'd1;
            end
        end else begin
            state_r <= HOLD;
        end
    end

    // Capture, frame hand-off and error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_r        <= 8'h00;
            shadow_r      <= 32'h0000_0000;
            digits_r      <= 32'h0000_0000;
            frame_valid_r <= 1'b0;
            err_pulse_r   <= 1'b0;
            en_err_r      <= 1'b0;
            seg_err_r     <= 1'b0;
            dp_err_r      <= 1'b0;
        end else begin
            shadow_r      <= cap_shadow_s;
            frame_valid_r <= frame_done_s;
            err_pulse_r   <= en_hit_s | seg_hit_s | dp_hit_s;
            en_err_r      <= en_err_r | en_hit_s;
            seg_err_r     <= seg_err_r | seg_hit_s;
            dp_err_r      <= dp_err_r | dp_hit_s;
            if (frame_done_s) begin
                mask_r   <= 8'h00;
                digits_r <= cap_shadow_s;
            end else begin
                mask_r <= cap_mask_s;
            end
        end
    end

    // Stall watchdog: saturating count since the last completed frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_r       <= {TO_W{1'b0}};
            scan_timeout_r <= 1'b0;
        end else if (frame_valid_r) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else if (to_cnt_r != TO_MAX) begin
            to_cnt_r <= to_cnt_r + TO_ONE;
            if (to_cnt_r == TO_LAST) begin
                scan_timeout_r <= 1'b1;
            end
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end

    assign digits       = digits_r;
    assign frame_valid  = frame_valid_r;
    assign en_err       = en_err_r;
    assign seg_err      = seg_err_r;
    assign dp_err       = dp_err_r;
    assign scan_timeout = scan_timeout_r;
    assign err_pulse    = err_pulse_r;

endmodule

// File: tb/tb_led_scan_decoder.sv
// Bench for led_scan_decoder: directed scans plus randomized display intervals
// checked against an interval-level model of the display being observed.
module tb_led_scan_decoder;

    localparam int STABLE_CYC  = 4;
    localparam int TIMEOUT_CYC = 2000;
    localparam int TO_W        = 11;
    localparam logic [6:0] SEG_TBL [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                            7'b0000000, 7'b0011000};

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  led_en;
    logic        led_ca, led_cb, led_cc, led_cd, led_ce, led_cf, led_cg, led_dp;
    logic [31:0] digits;
    logic        frame_valid, en_err, seg_err, dp_err, scan_timeout, err_pulse;

    always #5 clk = ~clk;

    led_scan_decoder #(.STABLE_CYC(STABLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC), .TO_W(TO_W)) dut (
        .clk(clk), .rst(rst), .led_en(led_en),
        .led_ca(led_ca), .led_cb(led_cb), .led_cc(led_cc), .led_cd(led_cd),
        .led_ce(led_ce), .led_cf(led_cf), .led_cg(led_cg), .led_dp(led_dp),
        .digits(digits), .frame_valid(frame_valid), .en_err(en_err), .seg_err(seg_err),
        .dp_err(dp_err), .scan_timeout(scan_timeout), .err_pulse(err_pulse)
    );

    int checks_s = 0;
    int errors_s = 0;

    // Model of what a correct decoder knows about the observed display.
    logic [3:0]  m_shadow [8];
    bit          m_seen [8];
    logic [31:0] m_digits;
    bit          m_en_err, m_seg_err, m_dp_err, m_to;
    int          cyc;
    bit          to_watch;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_s++;
        if (got !== exp) begin
            errors_s++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] ref_decode(input logic [6:0] s);
        if (s == 7'h7F) return {1'b0, 4'hF};
        for (int d = 0; d < 10; d++) begin
            if (SEG_TBL[d] == s) return {1'b0, 4'(d)};
        end
        return {1'b1, 4'hE};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_shadow[i] = 4'h0;
            m_seen[i]   = 1'b0;
        end
        m_digits = 32'h0; m_en_err = 1'b0; m_seg_err = 1'b0; m_dp_err = 1'b0; m_to = 1'b0;
    endtask

    // One accepted display interval: returns expected frame and error pulse counts.
    task automatic model_accept(input logic [7:0] en, input logic [6:0] seg, input logic dp,
                                output int fv, output int ep);
        int lows, p;
        logic [4:0] dec;
        bit all_seen;
        lows = 0; p = 0; fv = 0; ep = 0;
        for (int i = 0; i < 8; i++) begin
            if (en[i] == 1'b0) begin lows++; p = i; end
        end
        if (lows >= 2) begin
            m_en_err = 1'b1; ep = 1;
        end else if (lows == 1) begin
            dec = ref_decode(seg);
            if (dec[4]) m_seg_err = 1'b1;
            if (!dp) m_dp_err = 1'b1;
            ep = (dec[4] || !dp) ? 1 : 0;
            m_shadow[p] = dec[3:0];
            m_seen[p] = 1'b1;
            all_seen = 1'b1;
            for (int i = 0; i < 8; i++) all_seen &= m_seen[i];
            if (all_seen) begin
                for (int i = 0; i < 8; i++) begin
                    m_digits[4*i +: 4] = m_shadow[i];
                    m_seen[i] = 1'b0;
                end
                fv = 1;
            end
        end
    endtask

    // Hold one bus pattern for len cycles; lengths used are <=3 (ghost) or >=6 (real).
    task automatic drive(input logic [7:0] en, input logic [6:0] seg, input logic dp,
                         input int len, input string tag);
        int fv_seen, ep_seen, fv_exp, ep_exp;
        led_en = en; led_dp = dp;
        {led_cg, led_cf, led_ce, led_cd, led_cc, led_cb, led_ca} = seg;
        fv_seen = 0; ep_seen = 0; fv_exp = 0; ep_exp = 0;
        for (int k = 0; k < len; k++) begin
            @(posedge clk); #1;
            cyc++;
            fv_seen += int'(frame_valid);
            ep_seen += int'(err_pulse);
            // no frame completes in the runs long enough to reach the limit
            if (cyc >= TIMEOUT_CYC) m_to = 1'b1;
            if (to_watch && (cyc == TIMEOUT_CYC - 1 || cyc == TIMEOUT_CYC))
                check_val("timeout_edge", {31'd0, scan_timeout}, {31'd0, m_to});
        end
        if (len >= STABLE_CYC) model_accept(en, seg, dp, fv_exp, ep_exp);
        check_val({tag, "_fv"}, fv_seen, fv_exp);
        check_val({tag, "_ep"}, ep_seen, ep_exp);
        check_val({tag, "_digits"}, digits, m_digits);
        check_val({tag, "_flags"}, {28'd0, en_err, seg_err, dp_err, scan_timeout},
                  {28'd0, m_en_err, m_seg_err, m_dp_err, m_to});
    endtask

    task automatic do_reset();
        rst = 1'b1; led_en = 8'hFF; led_dp = 1'b1;
        {led_cg, led_cf, led_ce, led_cd, led_cc, led_cb, led_ca} = 7'h7F;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        cyc = 0;
        check_val("rst_digits", digits, 32'h0);
        check_val("rst_outs", {26'd0, frame_valid, en_err, seg_err, dp_err, scan_timeout, err_pulse}, 32'h0);
        drive(8'hFF, 7'h7F, 1'b1, 8, "idle");
    endtask

    function automatic logic [7:0] pos_en(input int p);
        logic [7:0] one;
        one = 8'd1;
        return ~(one << p);
    endfunction

    logic [7:0] en_v, prev_en;
    logic [6:0] seg_v, prev_seg;
    logic [4:0] dec_v;
    logic       dp_v, prev_dp;
    int         len_v, pctr, r, a, b;

    initial begin
        to_watch = 1'b0;
        do_reset();

        // Plain scan of 0..7
        for (int i = 0; i < 8; i++) drive(pos_en(i), SEG_TBL[i], 1'b1, 8, "scan07");
        check_val("scan07_value", digits, 32'h76543210);

        // Ghost pattern before every digit of a scan of 9s
        for (int i = 0; i < 8; i++) begin
            drive(8'hFE, 7'b0000000, 1'b1, 2, "ghost");
            drive(pos_en(i), SEG_TBL[9], 1'b1, 8, "nines");
        end
        check_val("nines_value", digits, 32'h99999999);

        // Two enables low at once
        drive(8'hFC, SEG_TBL[1], 1'b1, 8, "multi");

        // Undecodable segments with dp at position 3
        for (int i = 0; i < 8; i++) begin
            if (i == 3) drive(pos_en(i), 7'b1010101, 1'b0, 8, "badpos");
            else        drive(pos_en(i), SEG_TBL[i], 1'b1, 8, "badpos");
        end
        check_val("badpos_nibble", {28'd0, digits[15:12]}, 32'hE);

        // Reset part-way through a frame
        do_reset();
        for (int i = 0; i < 5; i++) drive(pos_en(i), SEG_TBL[9 - i], 1'b1, 8, "partial");
        do_reset();
        for (int i = 0; i < 8; i++) drive(pos_en(i), SEG_TBL[(i + 3) % 10], 1'b1, 8, "postrst");

        // Digits held too briefly: nothing accepted, watchdog fires
        do_reset();
        to_watch = 1'b1;
        for (int k = 0; cyc < TIMEOUT_CYC + 6; k++) drive(pos_en(k % 8), SEG_TBL[k % 10], 1'b1, 3, "short");
        to_watch = 1'b0;
        check_val("timeout_set", {31'd0, scan_timeout}, 32'd1);
        drive(8'hFF, 7'h7F, 1'b1, 8, "idle2");
        for (int i = 0; i < 8; i++) drive(pos_en(i), SEG_TBL[i], 1'b1, 8, "after_to");

        // Randomized intervals
        do_reset();
        prev_en = 8'hFF; prev_seg = 7'h7F; prev_dp = 1'b1; pctr = 0;
        for (int n = 0; n < 200; n++) begin
            r = int'($urandom_range(0, 99));
            dp_v = 1'b1;
            seg_v = SEG_TBL[$urandom_range(0, 9)];
            len_v = int'($urandom_range(6, 10));
            if (r < 20) begin
                en_v = pos_en(int'($urandom_range(0, 7)));
                len_v = int'($urandom_range(1, 3));
            end else if (r < 28) begin
                en_v = 8'hFF; seg_v = 7'h7F;
            end else if (r < 36) begin
                a = int'($urandom_range(0, 7));
                b = (a + int'($urandom_range(1, 7))) % 8;
                en_v = pos_en(a) & pos_en(b);
            end else begin
                en_v = pos_en(pctr % 8);
                pctr++;
                r = int'($urandom_range(0, 99));
                if (r < 8) seg_v = 7'h7F;
                else if (r < 15) begin
                    do begin
                        seg_v = 7'($urandom_range(0, 127));
                        dec_v = ref_decode(seg_v);
                    end while (!dec_v[4]);
                end
                dp_v = ($urandom_range(0, 9) == 0) ? 1'b0 : 1'b1;
            end
            if (en_v == prev_en && seg_v == prev_seg && dp_v == prev_dp) continue;
            drive(en_v, seg_v, dp_v, len_v, "rand");
            prev_en = en_v; prev_seg = seg_v; prev_dp = dp_v;
        end

        $display("CHECKS %0d ERRORS %0d", checks_s, errors_s);
        $finish;
    end

endmodule
